port_table_loader: RTL and testbench

- Control-plane writer for the port-group lookup tables that the port-match pipeline reads: pg entry, single-value, range, list, and HTTP src/dst port bitmaps.
- Accepts a valid/ready configuration command stream and issues write strobes to the tables' write ports.
- Performs a full zero-clear of every table after reset and on command.
- Implements per-port bit-set and bit-clear into the 2048x32 HTTP bitmaps by read-modify-write through each bitmap's read port, which has 2-cycle read latency.

---
 rtl/port_table_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 tb/tb_port_table_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_table_loader.sv
// port_table_loader: control-plane writer for the port-match lookup tables.
// Zero-clears every table after reset or on command. Applies direct table
// writes from a valid/ready command stream. Sets or clears single port bits
// in the HTTP src/dst bitmaps by read-modify-write through their 2-cycle read
// ports.
module port_table_loader #(
    parameter int PG_AWIDTH  = 9,
    parameter int PG_ENTRY_W = 32,
    parameter int RANGE_W    = 112,
    parameter int LIST_W     = 112
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [2:0]            cfg_op,
    input  logic [15:0]           cfg_addr,
    input  logic [127:0]          cfg_data,

    output logic                  pg_we,
    output logic [PG_AWIDTH-1:0]  pg_waddr,
    output logic [PG_ENTRY_W-1:0] pg_wdata,

    output logic                  single_we,
    output logic [PG_AWIDTH-1:0]  single_waddr,
    output logic [15:0]           single_wdata,

    output logic                  range_we,
    output logic [4:0]            range_waddr,
    output logic [RANGE_W-1:0]    range_wdata,

    output logic                  list_we,
    output logic [4:0]            list_waddr,
    output logic [LIST_W-1:0]     list_wdata,

    output logic                  http_src_we,
    output logic [10:0]           http_src_waddr,
    output logic [31:0]           http_src_wdata,

    output logic                  http_dst_we,
    output logic [10:0]           http_dst_waddr,
    output logic [31:0]           http_dst_wdata,

    output logic [10:0]           http_src_raddr,
    input  logic [31:0]           http_src_rdata,
    output logic [10:0]           http_dst_raddr,
    input  logic [31:0]           http_dst_rdata,

    output logic                  init_done,
    output logic [15:0]           err_cnt
);

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_RMW_RD, S_RMW_W1, S_RMW_W2, S_RMW_WR
    } state_t;

    typedef enum logic [2:0] {
        OP_PG       = 3'd0,
        OP_SINGLE   = 3'd1,
        OP_RANGE    = 3'd2,
        OP_LIST     = 3'd3,
        OP_SRC_SET  = 3'd4,
        OP_DST_SET  = 3'd5,
        OP_HTTP_CLR = 3'd6,
        OP_CLR_ALL  = 3'd7
    } op_t;

    state_t      state, state_n;
    logic [10:0] clr_cnt, clr_cnt_n;

    // Latched bit-op context: target word/bit, which bitmap, set vs clear.
    logic [10:0] rmw_word, rmw_word_n;
    logic [4:0]  rmw_bit, rmw_bit_n;
    logic        rmw_dst, rmw_dst_n;
    logic        rmw_clr, rmw_clr_n;

    // Next values of the registered outputs.
    logic                  cfg_ready_n;
    logic                  pg_we_n;
    logic [PG_AWIDTH-1:0]  pg_waddr_n;
    logic [PG_ENTRY_W-1:0] pg_wdata_n;
    logic                  single_we_n;
    logic [PG_AWIDTH-1:0]  single_waddr_n;
    logic [15:0]           single_wdata_n;
    logic                  range_we_n;
    logic [4:0]            range_waddr_n;
    logic [RANGE_W-1:0]    range_wdata_n;
    logic                  list_we_n;
    logic [4:0]            list_waddr_n;
    logic [LIST_W-1:0]     list_wdata_n;
    logic                  http_src_we_n;
    logic [10:0]           http_src_waddr_n;
    logic [31:0]           http_src_wdata_n;
    logic                  http_dst_we_n;
    logic [10:0]           http_dst_waddr_n;
    logic [31:0]           http_dst_wdata_n;
    logic [10:0]           http_src_raddr_n;
    logic [10:0]           http_dst_raddr_n;
    logic                  init_done_n;
    logic [15:0]           err_cnt_n;

    op_t         op;
    logic        accept;
    logic [15:0] err_inc;
    logic [31:0] bit_mask;
    logic [31:0] rmw_cur;
    logic        unused_bits;

    assign op       = op_t'(cfg_op);
    assign accept   = cfg_valid && cfg_ready;
    assign err_inc  = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
    assign bit_mask = 32'd1 << rmw_bit;
    assign rmw_cur  = rmw_dst ? http_dst_rdata : http_src_rdata;
    // Command data beyond the widest table is never used.
    assign unused_bits = ^cfg_data[127:112];

    // Next-state, next-output and bookkeeping logic for the loader FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
        state_n          = state;
        clr_cnt_n        = clr_cnt;
        rmw_word_n       = rmw_word;
        rmw_bit_n        = rmw_bit;
        rmw_dst_n        = rmw_dst;
        rmw_clr_n        = rmw_clr;
        cfg_ready_n      = 1'b0;
        init_done_n      = init_done;
        err_cnt_n        = err_cnt;
        pg_we_n          = 1'b0;
        pg_waddr_n       = '0;
        pg_wdata_n       = '0;
        single_we_n      = 1'b0;
        single_waddr_n   = '0;
        single_wdata_n   = '0;
        range_we_n       = 1'b0;
        range_waddr_n    = '0;
        range_wdata_n    = '0;
        list_we_n        = 1'b0;
        list_waddr_n     = '0;
        list_wdata_n     = '0;
        http_src_we_n    = 1'b0;
        http_src_waddr_n = '0;
        http_src_wdata_n = '0;
        http_dst_we_n    = 1'b0;
        http_dst_waddr_n = '0;
        http_dst_wdata_n = '0;
        http_src_raddr_n = '0;
        http_dst_raddr_n = '0;

        case (state)
            S_CLEAR: begin
                // Zero one address per cycle in every table deep enough to hold it.
                init_done_n      = 1'b0;
                http_src_we_n    = 1'b1;
                http_src_waddr_n = clr_cnt;
                http_dst_we_n    = 1'b1;
                http_dst_waddr_n = clr_cnt;
                if ((clr_cnt >> PG_AWIDTH) == 11'd0) begin
                    pg_we_n        = 1'b1;
                    pg_waddr_n     = clr_cnt[PG_AWIDTH-1:0];
                    single_we_n    = 1'b1;
                    single_waddr_n = clr_cnt[PG_AWIDTH-1:0];
                end
                if (clr_cnt[10:5] == 6'd0) begin
                    range_we_n    = 1'b1;
                    range_waddr_n = clr_cnt[4:0];
                    list_we_n     = 1'b1;
                    list_waddr_n  = clr_cnt[4:0];
                end
                clr_cnt_n = clr_cnt + 11'd1;
                if (clr_cnt == 11'd2047) begin
                    state_n = S_IDLE;
                end
            end

            S_IDLE: begin
                cfg_ready_n = 1'b1;
                init_done_n = 1'b1;
                if (accept) begin
                    case (op)
                        OP_PG: begin
                            if ((cfg_addr >> PG_AWIDTH) != 16'd0) begin
                                err_cnt_n = err_inc;
                            end else begin
                                pg_we_n    = 1'b1;
                                pg_waddr_n = cfg_addr[PG_AWIDTH-1:0];
                                pg_wdata_n = cfg_data[PG_ENTRY_W-1:0];
                            end
                        end
                        OP_SINGLE: begin
                            if ((cfg_addr >> PG_AWIDTH) != 16'd0) begin
                                err_cnt_n = err_inc;
                            end else begin
                                single_we_n    = 1'b1;
                                single_waddr_n = cfg_addr[PG_AWIDTH-1:0];
                                single_wdata_n = cfg_data[15:0];
                            end
                        end
                        OP_RANGE: begin
                            if (cfg_addr[15:5] != 11'd0) begin
                                err_cnt_n = err_inc;
                            end else begin
                                range_we_n    = 1'b1;
                                range_waddr_n = cfg_addr[4:0];
                                range_wdata_n = cfg_data[RANGE_W-1:0];
                            end
                        end
                        OP_LIST: begin
                            if (cfg_addr[15:5] != 11'd0) begin
                                err_cnt_n = err_inc;
                            end else begin
                                list_we_n    = 1'b1;
                                list_waddr_n = cfg_addr[4:0];
                                list_wdata_n = cfg_data[LIST_W-1:0];
                            end
                        end
                        OP_SRC_SET, OP_DST_SET, OP_HTTP_CLR: begin
                            // Launch the read now so the address is valid during RMW_RD.
                            rmw_word_n  = cfg_addr[15:5];
                            rmw_bit_n   = cfg_addr[4:0];
                            rmw_clr_n   = (op == OP_HTTP_CLR);
                            rmw_dst_n   = (op == OP_DST_SET) ||
                                          ((op == OP_HTTP_CLR) && cfg_data[0]);
                            if (rmw_dst_n) begin
                                http_dst_raddr_n = cfg_addr[15:5];
                            end else begin
                                http_src_raddr_n = cfg_addr[15:5];
                            end
                            cfg_ready_n = 1'b0;
                            state_n     = S_RMW_RD;
                        end
                        OP_CLR_ALL: begin
                            cfg_ready_n = 1'b0;
                            init_done_n = 1'b0;
                            clr_cnt_n   = 11'd0;
                            state_n     = S_CLEAR;
                        end
                        default: ;
                    endcase
                end
            end

            S_RMW_RD, S_RMW_W1, S_RMW_W2: begin
                // Hold the read address through RMW_WR so rdata is stable when sampled.
                if (rmw_dst) begin
                    http_dst_raddr_n = rmw_word;
                end else begin
                    http_src_raddr_n = rmw_word;
                end
                case (state)
                    S_RMW_RD: state_n = S_RMW_W1;
                    S_RMW_W1: state_n = S_RMW_W2;
                    default:  state_n = S_RMW_WR;
                endcase
            end

            S_RMW_WR: begin
                // Merge the target bit into the read word and write it back.
                if (rmw_dst) begin
                    http_dst_we_n    = 1'b1;
                    http_dst_waddr_n = rmw_word;
                    http_dst_wdata_n = rmw_clr ? (rmw_cur & ~bit_mask) : (rmw_cur | bit_mask);
                end else begin
                    http_src_we_n    = 1'b1;
                    http_src_waddr_n = rmw_word;
                    http_src_wdata_n = rmw_clr ? (rmw_cur & ~bit_mask) : (rmw_cur | bit_mask);
                end
                cfg_ready_n = 1'b1;
                state_n     = S_IDLE;
            end

            default: begin
                state_n   = S_CLEAR;
                clr_cnt_n = 11'd0;
            end
        endcase
    end

    // FSM state, clear counter and bit-op context registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= S_CLEAR;
            clr_cnt  <= 11'd0;
            rmw_word <= 11'd0;
            rmw_bit  <= 5'd0;
            rmw_dst  <= 1'b0;
            rmw_clr  <= 1'b0;
        end else begin
            state    <= state_n;
            clr_cnt  <= clr_cnt_n;
            rmw_word <= rmw_word_n;
            rmw_bit  <= rmw_bit_n;
            rmw_dst  <= rmw_dst_n;
            rmw_clr  <= rmw_clr_n;
        end
    end

    // Output registers; reset drops every strobe immediately, aborting any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready      <= 1'b0;
            init_done      <= 1'b0;
            err_cnt        <= 16'd0;
            pg_we          <= 1'b0;
            pg_waddr       <= '0;
            pg_wdata       <= '0;
            single_we      <= 1'b0;
            single_waddr   <= '0;
            single_wdata   <= '0;
            range_we       <= 1'b0;
            range_waddr    <= '0;
            range_wdata    <= '0;
            list_we        <= 1'b0;
            list_waddr     <= '0;
            list_wdata     <= '0;
            http_src_we    <= 1'b0;
            http_src_waddr <= '0;
            http_src_wdata <= '0;
            http_dst_we    <= 1'b0;
            http_dst_waddr <= '0;
            http_dst_wdata <= '0;
            http_src_raddr <= '0;
            http_dst_raddr <= '0;
        end else begin
            cfg_ready      <= cfg_ready_n;
            init_done      <= init_done_n;
            err_cnt        <= err_cnt_n;
            pg_we          <= pg_we_n;
            pg_waddr       <= pg_waddr_n;
            pg_wdata       <= pg_wdata_n;
            single_we      <= single_we_n;
            single_waddr   <= single_waddr_n;
            single_wdata   <= single_wdata_n;
            range_we       <= range_we_n;
            range_waddr    <= range_waddr_n;
            range_wdata    <= range_wdata_n;
            list_we        <= list_we_n;
            list_waddr     <= list_waddr_n;
            list_wdata     <= list_wdata_n;
            http_src_we    <= http_src_we_n;
            http_src_waddr <= http_src_waddr_n;
            http_src_wdata <= http_src_wdata_n;
            http_dst_we    <= http_dst_we_n;
            http_dst_waddr <= http_dst_waddr_n;
            http_dst_wdata <= http_dst_wdata_n;
            http_src_raddr <= http_src_raddr_n;
            http_dst_raddr <= http_dst_raddr_n;
        end
    end

endmodule

// File: tb/tb_port_table_loader.sv
// Directed testbench for port_table_loader with a 2-cycle-latency bitmap model.
module tb_port_table_loader;

    localparam int PG_AWIDTH  = 9;
    localparam int PG_ENTRY_W = 32;
    localparam int RANGE_W    = 112;
    localparam int LIST_W     = 112;

    logic                  clk;
    logic                  rst;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [2:0]            cfg_op;
    logic [15:0]           cfg_addr;
    logic [127:0]          cfg_data;
    logic                  pg_we;
    logic [PG_AWIDTH-1:0]  pg_waddr;
    logic [PG_ENTRY_W-1:0] pg_wdata;
    logic                  single_we;
    logic [PG_AWIDTH-1:0]  single_waddr;
    logic [15:0]           single_wdata;
    logic                  range_we;
    logic [4:0]            range_waddr;
    logic [RANGE_W-1:0]    range_wdata;
    logic                  list_we;
    logic [4:0]            list_waddr;
    logic [LIST_W-1:0]     list_wdata;
    logic                  http_src_we;
    logic [10:0]           http_src_waddr;
    logic [31:0]           http_src_wdata;
    logic                  http_dst_we;
    logic [10:0]           http_dst_waddr;
    logic [31:0]           http_dst_wdata;
    logic [10:0]           http_src_raddr;
    logic [31:0]           http_src_rdata;
    logic [10:0]           http_dst_raddr;
    logic [31:0]           http_dst_rdata;
    logic                  init_done;
    logic [15:0]           err_cnt;

    int checks = 0;
    int errors = 0;

    port_table_loader #(
        .PG_AWIDTH(PG_AWIDTH), .PG_ENTRY_W(PG_ENTRY_W),
        .RANGE_W(RANGE_W), .LIST_W(LIST_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .pg_we(pg_we), .pg_waddr(pg_waddr), .pg_wdata(pg_wdata),
        .single_we(single_we), .single_waddr(single_waddr), .single_wdata(single_wdata),
        .range_we(range_we), .range_waddr(range_waddr), .range_wdata(range_wdata),
        .list_we(list_we), .list_waddr(list_waddr), .list_wdata(list_wdata),
        .http_src_we(http_src_we), .http_src_waddr(http_src_waddr), .http_src_wdata(http_src_wdata),
        .http_dst_we(http_dst_we), .http_dst_waddr(http_dst_waddr), .http_dst_wdata(http_dst_wdata),
        .http_src_raddr(http_src_raddr), .http_src_rdata(http_src_rdata),
        .http_dst_raddr(http_dst_raddr), .http_dst_rdata(http_dst_rdata),
        .init_done(init_done), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bitmap models: write port plus a read port with two register stages.
    logic [31:0] src_mem [2048];
    logic [31:0] dst_mem [2048];
    logic [31:0] src_p1, dst_p1;

    always @(posedge clk) begin
        src_p1         <= src_mem[http_src_raddr];
        http_src_rdata <= src_p1;
        dst_p1         <= dst_mem[http_dst_raddr];
        http_dst_rdata <= dst_p1;
        if (http_src_we) src_mem[http_src_waddr] <= http_src_wdata;
        if (http_dst_we) dst_mem[http_dst_waddr] <= http_dst_wdata;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Observes a full clear starting at the next edge (edge 1 writes address 0).
    task automatic clear_watch(input string tag);
        int src_n = 0, dst_n = 0, pg_n = 0, sg_n = 0, rg_n = 0, ls_n = 0;
        int done_at = 0, bad_data = 0, bad_addr = 0, early_rdy = 0;
        for (int k = 1; k <= 2060; k++) begin
            @(negedge clk);
            if (k == 4) cfg_valid = 1'b0;
            if (http_src_we) begin
                if (http_src_waddr != 11'(src_n)) bad_addr++;
                if (http_src_wdata != 32'd0) bad_data++;
                src_n++;
            end
            if (http_dst_we) begin
                if (http_dst_wdata != 32'd0) bad_data++;
                dst_n++;
            end
            if (pg_we) begin
                if (pg_waddr != PG_AWIDTH'(pg_n)) bad_addr++;
                if (pg_wdata != '0) bad_data++;
                pg_n++;
            end
            if (single_we) begin
                if (single_wdata != 16'd0) bad_data++;
                sg_n++;
            end
            if (range_we) begin
                if (range_wdata != '0) bad_data++;
                rg_n++;
            end
            if (list_we) begin
                if (list_wdata != '0) bad_data++;
                ls_n++;
            end
            if (init_done && done_at == 0) done_at = k;
            if (cfg_ready && done_at == 0) early_rdy++;
        end
        check({tag, "_src_we_cycles"}, 128'(src_n), 128'd2048);
        check({tag, "_dst_we_cycles"}, 128'(dst_n), 128'd2048);
        check({tag, "_pg_we_cycles"}, 128'(pg_n), 128'd512);
        check({tag, "_single_we_cycles"}, 128'(sg_n), 128'd512);
        check({tag, "_range_we_cycles"}, 128'(rg_n), 128'd32);
        check({tag, "_list_we_cycles"}, 128'(ls_n), 128'd32);
        check({tag, "_bad_waddr"}, 128'(bad_addr), 128'd0);
        check({tag, "_nonzero_wdata"}, 128'(bad_data), 128'd0);
        check({tag, "_init_done_cycle"}, 128'(done_at), 128'd2049);
        check({tag, "_early_ready"}, 128'(early_rdy), 128'd0);
    endtask

    // Presents one command at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [2:0] op, input logic [15:0] addr, input logic [127:0] data);
        int w = 0;
        while (!cfg_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (!cfg_ready) check("ready_timeout", 128'(cfg_ready), 128'd1);
        cfg_valid = 1'b1;
        cfg_op    = op;
        cfg_addr  = addr;
        cfg_data  = data;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Follows a bit op from the cycle after acceptance until cfg_ready returns.
    task automatic rmw_watch(input logic dst, output int low, output logic seen,
                             output logic [10:0] wa, output logic [31:0] wd);
        low  = cfg_ready ? 0 : 1;
        seen = 1'b0;
        wa   = '0;
        wd   = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dst ? http_dst_we : http_src_we) begin
                seen = 1'b1;
                wa   = dst ? http_dst_waddr : http_src_waddr;
                wd   = dst ? http_dst_wdata : http_src_wdata;
            end
            if (cfg_ready) break;
            low++;
        end
    endtask

    int          low;
    logic        seen;
    logic [10:0] wa;
    logic [31:0] wd;
    int          cnt;

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_op    = 3'd0;
        cfg_addr  = 16'd0;
        cfg_data  = '0;
        for (int i = 0; i < 2048; i++) begin
            src_mem[i] = 32'hDEAD_0000 | 32'(i);
            dst_mem[i] = 32'hBEEF_0000 | 32'(i);
        end
        repeat (4) @(negedge clk);
        check("rst_cfg_ready", 128'(cfg_ready), 128'd0);
        check("rst_init_done", 128'(init_done), 128'd0);
        check("rst_err_cnt", 128'(err_cnt), 128'd0);
        check("rst_src_we", 128'(http_src_we), 128'd0);
        check("rst_pg_waddr", 128'(pg_waddr), 128'd0);

        // A command held valid across reset release must not be accepted.
        cfg_valid = 1'b1;
        cfg_op    = 3'd0;
        cfg_addr  = 16'd7;
        cfg_data  = 128'h1234;
        rst       = 1'b0;
        clear_watch("init");
        check("post_clear_ready", 128'(cfg_ready), 128'd1);
        check("post_clear_src_mem", 128'(src_mem[100]), 128'd0);

        // Back-to-back direct writes.
        cfg_valid = 1'b1;
        cfg_op    = 3'd0;
        cfg_addr  = 16'h0005;
        cfg_data  = 128'hA5A5A5A5;
        @(negedge clk);
        check("pg_we", 128'(pg_we), 128'd1);
        check("pg_waddr", 128'(pg_waddr), 128'd5);
        check("pg_wdata", 128'(pg_wdata), 128'hA5A5A5A5);
        cfg_op    = 3'd1;
        cfg_addr  = 16'h01FF;
        cfg_data  = 128'h0050;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("single_we", 128'(single_we), 128'd1);
        check("single_waddr", 128'(single_waddr), 128'h1FF);
        check("single_wdata", 128'(single_wdata), 128'h0050);
        check("pg_we_one_cycle", 128'(pg_we), 128'd0);
        @(negedge clk);
        check("single_we_one_cycle", 128'(single_we), 128'd0);

        // Source bit set: port 80 -> word 2 bit 16.
        src_mem[2] = 32'h0000_0001;
        send(3'd4, 16'd80, '0);
        check("src_set_ready_drop", 128'(cfg_ready), 128'd0);
        check("src_set_raddr", 128'(http_src_raddr), 128'd2);
        rmw_watch(1'b0, low, seen, wa, wd);
        check("src_set_ready_low", 128'(low), 128'd4);
        check("src_set_we", 128'(seen), 128'd1);
        check("src_set_waddr", 128'(wa), 128'd2);
        check("src_set_wdata", 128'(wd), 128'h0001_0001);
        @(negedge clk);
        check("src_set_raddr_idle", 128'(http_src_raddr), 128'd0);
        check("src_set_mem", 128'(src_mem[2]), 128'h0001_0001);

        // Destination set then clear: port 443 -> word 13 bit 27.
        dst_mem[13] = 32'h0000_00F0;
        send(3'd5, 16'd443, '0);
        check("dst_set_raddr", 128'(http_dst_raddr), 128'd13);
        rmw_watch(1'b1, low, seen, wa, wd);
        check("dst_set_waddr", 128'(wa), 128'd13);
        check("dst_set_wdata", 128'(wd), 128'h0800_00F0);
        @(negedge clk);
        check("dst_set_mem", 128'(dst_mem[13]), 128'h0800_00F0);
        send(3'd6, 16'd443, 128'd1);
        rmw_watch(1'b1, low, seen, wa, wd);
        check("dst_clr_wdata", 128'(wd), 128'h0000_00F0);
        @(negedge clk);
        check("dst_clr_mem", 128'(dst_mem[13]), 128'h0000_00F0);

        // Source clear restores the original word.
        send(3'd6, 16'd80, 128'd0);
        rmw_watch(1'b0, low, seen, wa, wd);
        check("src_clr_we", 128'(seen), 128'd1);
        check("src_clr_wdata", 128'(wd), 128'h0000_0001);

        // Address range checks.
        send(3'd2, 16'd40, 128'hFFFF);
        check("range_oob_no_we", 128'(range_we), 128'd0);
        check("range_oob_err", 128'(err_cnt), 128'd1);
        send(3'd0, 16'h0200, 128'hFFFF);
        check("pg_oob_no_we", 128'(pg_we), 128'd0);
        check("pg_oob_err", 128'(err_cnt), 128'd2);
        send(3'd3, 16'd31, 128'hCAFE);
        check("list_edge_we", 128'(list_we), 128'd1);
        check("list_edge_waddr", 128'(list_waddr), 128'd31);
        check("list_edge_wdata", 128'(list_wdata), 128'hCAFE);
        check("list_edge_err", 128'(err_cnt), 128'd2);

        // Flood of bad commands: counter saturates.
        cnt       = 0;
        cfg_valid = 1'b1;
        cfg_op    = 3'd3;
        cfg_addr  = 16'd100;
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            if (list_we) cnt++;
        end
        cfg_valid = 1'b0;
        check("flood_no_list_we", 128'(cnt), 128'd0);
        check("err_saturate", 128'(err_cnt), 128'hFFFF);

        // Reset during RMW_W1 aborts the write-back.
        src_mem[0] = 32'h0000_0005;
        send(3'd4, 16'd3, '0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (http_src_we) cnt++;
        end
        check("rmw_abort_no_we", 128'(cnt), 128'd0);
        check("rmw_abort_mem", 128'(src_mem[0]), 128'h0000_0005);
        rst = 1'b0;
        clear_watch("rmw_abort");

        // Clear-all, interrupted by reset at c = 1000.
        send(3'd7, 16'd0, '0);
        check("clrall_init_done_drop", 128'(init_done), 128'd0);
        check("clrall_ready_drop", 128'(cfg_ready), 128'd0);
        repeat (1001) @(negedge clk);
        check("clrall_c1000_waddr", 128'(http_src_waddr), 128'd1000);
        rst = 1'b1;
        @(negedge clk);
        check("clrall_abort_we", 128'(http_src_we), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_watch("clrall_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
